// File: rtl/memory_pkg.sv
// Shared types and the address-region decoder for the memory router.
package memory_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExtCmd,
    StExtRd
  } state_e;

  typedef enum logic [1:0] {
    RegionSram,
    RegionExt,
    RegionErr
  } region_e;

  // Offset arithmetic is done in addr_w bits so a wrapped subtraction cannot alias into EXT.
  function automatic region_e decode_region(input logic [63:0] addr,
                                            input int unsigned addr_w,
                                            input int unsigned sram_aw,
                                            input int unsigned ext_aw);
    logic [63:0] sram_words;
    logic [63:0] addr_mask;
    logic [63:0] offset;
    sram_words = 64'd1 << sram_aw;
    addr_mask  = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
    if (addr < sram_words) begin
      return RegionSram;
    end
    offset = (addr - sram_words) & addr_mask;
    if (offset < (64'd1 << ext_aw)) begin
      return RegionExt;
    end
    return RegionErr;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port byte-enabled RAM with synchronous read; the read register only updates on reads.
module sram_bank #(
  parameter int unsigned AW     = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned Words = 2 ** AW;
  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] mem [Words];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (be[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/memory_router.sv
// Routes CPU word accesses to on-chip SRAM (low addresses) or the external controller,
// with a registered one-cycle response and error reporting for out-of-range or timed-out accesses.
module memory_router
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRAM_AW = 12,
  parameter int unsigned EXT_AW  = 27,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [EXT_AW-1:0]     ext_addr,
  output logic [DATA_W-1:0]     ext_wdata,
  output logic [DATA_W/8-1:0]   ext_be,
  output logic                  ext_read_req,
  output logic                  ext_write_req,
  input  logic                  ext_ack,
  input  logic                  ext_rvalid,
  input  logic [DATA_W-1:0]     ext_rdata
);

  localparam int unsigned SRAM_WORDS = 2 ** SRAM_AW;
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ready_q;
  logic [EXT_AW-1:0]   ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0]   ext_wdata_q, ext_wdata_d;
  logic [BE_W-1:0]     ext_be_q, ext_be_d;
  logic                ext_rd_q, ext_rd_d;
  logic                ext_wr_q, ext_wr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_sram_q, rdata_sram_d;

  region_e             region;
  logic                accept;
  logic                sram_en;
  logic                timed_out;
  logic [DATA_W-1:0]   sram_rdata;

  assign region    = decode_region(64'(req_addr), ADDR_W, SRAM_AW, EXT_AW);
  // ready_q keeps req_ready low while reset is asserted even though the state sits in StIdle.
  assign req_ready = ready_q && (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign sram_en   = accept && (region == RegionSram);
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  sram_bank #(
    .AW     (SRAM_AW),
    .DATA_W (DATA_W)
  ) u_sram_bank (
    .clk   (clk),
    .en    (sram_en),
    .we    (req_we),
    .addr  (req_addr[SRAM_AW-1:0]),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ext_addr_d   = ext_addr_q;
    ext_wdata_d  = ext_wdata_q;
    ext_be_d     = ext_be_q;
    ext_rd_d     = ext_rd_q;
    ext_wr_d     = ext_wr_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rdata_d      = rdata_q;
    rdata_sram_d = rdata_sram_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (region)
            RegionSram: begin
              rsp_valid_d = 1'b1;
              if (!req_we) begin
                rdata_sram_d = 1'b1;
              end
            end
            RegionExt: begin
              ext_addr_d  = EXT_AW'(req_addr - ADDR_W'(SRAM_WORDS));
              ext_wdata_d = req_wdata;
              ext_be_d    = req_be;
              ext_rd_d    = !req_we;
              ext_wr_d    = req_we;
              cnt_d       = '0;
              state_d     = StExtCmd;
            end
            default: begin
              rsp_valid_d  = 1'b1;
              rsp_err_d    = 1'b1;
              rdata_d      = '0;
              rdata_sram_d = 1'b0;
            end
          endcase
        end
      end
      StExtCmd, StExtRd: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (state_q == StExtCmd && ext_ack) begin
          ext_rd_d = 1'b0;
          ext_wr_d = 1'b0;
          if (ext_wr_q) begin
            rsp_valid_d = 1'b1;
            state_d     = StIdle;
          end else if (ext_rvalid) begin
            rsp_valid_d  = 1'b1;
            rdata_d      = ext_rdata;
            rdata_sram_d = 1'b0;
            state_d      = StIdle;
          end else begin
            state_d = StExtRd;
          end
        end else if (state_q == StExtRd && ext_rvalid) begin
          rsp_valid_d  = 1'b1;
          rdata_d      = ext_rdata;
          rdata_sram_d = 1'b0;
          state_d      = StIdle;
        end else if (timed_out) begin
          ext_rd_d     = 1'b0;
          ext_wr_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rdata_d      = '0;
          rdata_sram_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      ext_addr_q   <= '0;
      ext_wdata_q  <= '0;
      ext_be_q     <= '0;
      ext_rd_q     <= 1'b0;
      ext_wr_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rdata_q      <= '0;
      rdata_sram_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= 1'b1;
      ext_addr_q   <= ext_addr_d;
      ext_wdata_q  <= ext_wdata_d;
      ext_be_q     <= ext_be_d;
      ext_rd_q     <= ext_rd_d;
      ext_wr_q     <= ext_wr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rdata_q      <= rdata_d;
      rdata_sram_q <= rdata_sram_d;
    end
  end

  // SRAM read data stays in the RAM's read register until the next SRAM read.
  assign rsp_rdata     = rdata_sram_q ? sram_rdata : rdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign ext_addr      = ext_addr_q;
  assign ext_wdata     = ext_wdata_q;
  assign ext_be        = ext_be_q;
  assign ext_read_req  = ext_rd_q;
  assign ext_write_req = ext_wr_q;

endmodule
